fft_ram_arbiter: RTL

- Shares the FFT dual-port sample RAM between three requesters: the initial-value loader (L), the butterfly engine (E) and the host inspect/readout path (H).
- Issues at most one access per cycle through registered RAM-side ports.
- Supports an engine lock, so a butterfly read and its write-back are never interleaved with other traffic.
- Sits between the FFT top-level state machine and `dualport_ram`.

---
 rtl/fft_pkg.sv | 28 ++
 rtl/fft_arb_pick.sv | 42 ++++
 rtl/fft_ram_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: requester IDs, arbiter state encoding and default widths.
package fft_pkg;

  localparam int FFT_AW = 8;
  localparam int FFT_DW = 32;
  localparam int NREQ   = 3;

  typedef enum logic [1:0] {
    REQ_E = 2'd0,
    REQ_L = 2'd1,
    REQ_H = 2'd2
  } req_id_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Rotation order E -> L -> H -> E.
  function automatic req_id_e next_req(input req_id_e id);
    case (id)
      REQ_E:   return REQ_L;
      REQ_L:   return REQ_H;
      default: return REQ_E;
    endcase
  endfunction

endpackage

// File: rtl/fft_arb_pick.sv
// Combinational one-hot grant selector for the FFT RAM arbiter.
// FFT_ARB_RR_EN selects round-robin in IDLE; otherwise fixed priority E > L > H.
module fft_arb_pick
  import fft_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  arb_state_e      state,
  input  req_id_e         rr_last,
  output logic [NREQ-1:0] gnt
);

`ifdef FFT_ARB_RR_EN
  req_id_e cand_1;
  req_id_e cand_2;

  assign cand_1 = next_req(rr_last);
  assign cand_2 = next_req(cand_1);
`else
  logic unused_rr;

  assign unused_rr = ^rr_last;
`endif

  always_comb begin
    gnt = '0;
    if (state == ARB_LOCKED) begin
      // The engine owns the RAM until it drops its lock.
      gnt[REQ_E] = req[REQ_E];
    end else begin
`ifdef FFT_ARB_RR_EN
      if (req[cand_1])       gnt[cand_1]  = 1'b1;
      else if (req[cand_2])  gnt[cand_2]  = 1'b1;
      else if (req[rr_last]) gnt[rr_last] = 1'b1;
`else
      if (req[REQ_E])        gnt[REQ_E] = 1'b1;
      else if (req[REQ_L])   gnt[REQ_L] = 1'b1;
      else if (req[REQ_H])   gnt[REQ_H] = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/fft_ram_arbiter.sv
// Shares the FFT dual-port sample RAM between loader, butterfly engine and host.
// Arbitration mode is set by FFT_ARB_RR_EN (see fft_arb_pick).
module fft_ram_arbiter
  import fft_pkg::*;
#(
  parameter int AW = FFT_AW,
  parameter int DW = FFT_DW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          l_req,
  input  logic [AW-1:0] l_addr,
  input  logic [2*DW-1:0] l_din,
  output logic          l_gnt,
  input  logic          e_req,
  input  logic          e_lock,
  input  logic          e_we,
  input  logic [AW-1:0] e_addr_top,
  input  logic [AW-1:0] e_addr_bot,
  input  logic [2*DW-1:0] e_din_top,
  input  logic [2*DW-1:0] e_din_bot,
  output logic          e_gnt,
  output logic          e_rvalid,
  input  logic          h_req,
  input  logic [AW-1:0] h_addr,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [2*DW-1:0] rd_top,
  output logic [2*DW-1:0] rd_bot,
  output logic          busy,
  output logic          ram_we_top,
  output logic          ram_we_bot,
  output logic [AW-1:0] ram_addr_top,
  output logic [AW-1:0] ram_addr_bot,
  output logic [2*DW-1:0] ram_din_top,
  output logic [2*DW-1:0] ram_din_bot,
  input  logic [2*DW-1:0] ram_dout_top,
  input  logic [2*DW-1:0] ram_dout_bot
);

  arb_state_e      state_reg, state_next;
  req_id_e         rr_last_reg;
  logic [NREQ-1:0] req_vec;
  logic [NREQ-1:0] pick_gnt;
  logic [1:0]      e_inflight_reg;
  logic [1:0]      h_inflight_reg;

  assign req_vec[REQ_E] = e_req;
  assign req_vec[REQ_L] = l_req;
  assign req_vec[REQ_H] = h_req;

  fft_arb_pick u_pick (
    .req     (req_vec),
    .state   (state_reg),
    .rr_last (rr_last_reg),
    .gnt     (pick_gnt)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state_reg <= ARB_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE:   if (e_gnt && e_lock) state_next = ARB_LOCKED;
      ARB_LOCKED: if (!e_lock)         state_next = ARB_IDLE;
      default:                         state_next = ARB_IDLE;
    endcase
  end

  // Grants are held off during Reset so nothing is accepted and then dropped.
  always_comb begin
    e_gnt = pick_gnt[REQ_E] & ~Reset;
    l_gnt = pick_gnt[REQ_L] & ~Reset;
    h_gnt = pick_gnt[REQ_H] & ~Reset;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ram_we_top     <= 1'b0;
      ram_we_bot     <= 1'b0;
      ram_addr_top   <= '0;
      ram_addr_bot   <= '0;
      ram_din_top    <= '0;
      ram_din_bot    <= '0;
      e_inflight_reg <= '0;
      h_inflight_reg <= '0;
      rr_last_reg    <= REQ_H;
    end else begin
      ram_we_top     <= 1'b0;
      ram_we_bot     <= 1'b0;
      e_inflight_reg <= {e_inflight_reg[0], e_gnt & ~e_we};
      h_inflight_reg <= {h_inflight_reg[0], h_gnt};
      if (e_gnt) begin
        ram_we_top   <= e_we;
        ram_we_bot   <= e_we;
        ram_addr_top <= e_addr_top;
        ram_addr_bot <= e_addr_bot;
        ram_din_top  <= e_din_top;
        ram_din_bot  <= e_din_bot;
        rr_last_reg  <= REQ_E;
      end else if (l_gnt) begin
        ram_we_top   <= 1'b1;
        ram_addr_top <= l_addr;
        ram_din_top  <= l_din;
        rr_last_reg  <= REQ_L;
      end else if (h_gnt) begin
        ram_addr_top <= h_addr;
        rr_last_reg  <= REQ_H;
      end
    end
  end

  // Tag reaches stage 1 in the same cycle the RAM presents the read data.
  assign e_rvalid = e_inflight_reg[1];
  assign h_rvalid = h_inflight_reg[1];
  assign rd_top   = ram_dout_top;
  assign rd_bot   = ram_dout_bot;
  assign busy     = (state_reg == ARB_LOCKED) | (|e_inflight_reg) | (|h_inflight_reg);

endmodule
